// File: rtl/custom_subtractor45_3_seq.sv
// ---------------------------------------------------------------------------
// custom_subtractor45_3_seq
//
// Digit-serial subtractor computing Diff = A - zero_extend(B) as an
// (A_WIDTH+1)-bit two's-complement value. It undoes the 45-bit + 42-bit
// custom adder in the multiply/accumulate datapath. DIGIT bits are handled
// per clock, least-significant digit first, with the borrow carried from one
// digit to the next in a register.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operand pair A/B is valid
//   in_ready   block is idle and will accept an operand pair this cycle
//   A          minuend, unsigned, A_WIDTH bits
//   B          subtrahend, unsigned, B_WIDTH bits (zero-extended to A_WIDTH)
//   out_valid  Diff/Borrow hold a finished result
//   out_ready  consumer takes the result on this edge
//   Diff       two's-complement A - B; bit A_WIDTH is the sign
//   Borrow     1 iff A < B (same as Diff[A_WIDTH])
//
// One operation is in flight at a time: IDLE accepts, BUSY runs NUM_DIGITS
// digit steps, DONE holds the result until out_ready. A result appears
// NUM_DIGITS edges after acceptance; peak rate is one per NUM_DIGITS+2 cycles.
// ---------------------------------------------------------------------------
module custom_subtractor45_3_seq #(
    parameter int A_WIDTH = 45,
    parameter int B_WIDTH = 42,
    parameter int DIGIT   = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_WIDTH-1:0] A,
    input  logic [B_WIDTH-1:0] B,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [A_WIDTH:0]   Diff,
    output logic               Borrow
);

    localparam int NUM_DIGITS = A_WIDTH / DIGIT;
    localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    // Parameter sanity: a partial last digit or a subtrahend wider than the
    // minuend would silently corrupt the result, so refuse to elaborate.
    if ((A_WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("custom_subtractor45_3_seq: A_WIDTH must be a multiple of DIGIT");
    end
    if (B_WIDTH > A_WIDTH) begin : g_bad_bwidth
        $error("custom_subtractor45_3_seq: B_WIDTH must not exceed A_WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   digit_cnt;
    logic               borrow_q;
    logic [A_WIDTH-1:0] a_sr;
    logic [A_WIDTH-1:0] b_sr;
    logic [A_WIDTH-1:0] res_sr;

    logic [DIGIT:0]     sub_res;
    logic [DIGIT-1:0]   digit_d;
    logic               digit_bout;
    logic [A_WIDTH-1:0] res_next;

    // One digit of subtraction with borrow-in. Evaluated on DIGIT+1 bits so
    // the top bit of the wrapped result is exactly the borrow-out: the true
    // difference lies in [-2^DIGIT, 2^DIGIT - 1].
    function automatic logic [DIGIT:0] digit_sub(
        input logic [DIGIT-1:0] a_dig,
        input logic [DIGIT-1:0] b_dig,
        input logic             b_in
    );
        digit_sub = {1'b0, a_dig} - {1'b0, b_dig} - {{DIGIT{1'b0}}, b_in};
    endfunction

    // Ready is decoded from the state register and masked by reset so the
    // upstream stage never sees a handshake that reset is about to discard.
    assign in_ready = (state == IDLE) && !rst;

    // ---- digit step: low digits of the operand registers -> difference ----
    always_comb begin
        sub_res    = digit_sub(a_sr[DIGIT-1:0], b_sr[DIGIT-1:0], borrow_q);
        digit_d    = sub_res[DIGIT-1:0];
        digit_bout = sub_res[DIGIT];
        // New digit enters at the top; after NUM_DIGITS steps the first
        // (least-significant) digit has walked down to bit 0.
        res_next   = (res_sr >> DIGIT) | (A_WIDTH'(digit_d) << (A_WIDTH - DIGIT));
    end

    // ---- registered state: control FSM, shift registers, result ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            digit_cnt <= '0;
            borrow_q  <= 1'b0;
            a_sr      <= '0;
            b_sr      <= '0;
            res_sr    <= '0;
            out_valid <= 1'b0;
            Diff      <= '0;
            Borrow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        // Operands are captured here only; later changes on
                        // A/B cannot reach the computation.
                        a_sr      <= A;
                        b_sr      <= A_WIDTH'(B);
                        res_sr    <= '0;
                        borrow_q  <= 1'b0;
                        digit_cnt <= '0;
                        state     <= BUSY;
                    end
                end

                BUSY: begin
                    a_sr      <= a_sr >> DIGIT;
                    b_sr      <= b_sr >> DIGIT;
                    res_sr    <= res_next;
                    borrow_q  <= digit_bout;
                    digit_cnt <= digit_cnt + 1'b1;
                    if (digit_cnt == CNT_W'(NUM_DIGITS - 1)) begin
                        // Final borrow out of the top digit is the sign of
                        // the exact (A_WIDTH+1)-bit difference.
                        state     <= DONE;
                        out_valid <= 1'b1;
                        Diff      <= {digit_bout, res_next};
                        Borrow    <= digit_bout;
                    end
                end

                DONE: begin
                    // Result held indefinitely until the consumer takes it;
                    // Diff/Borrow are left as-is afterwards.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_custom_subtractor45_3_seq.sv
// ---------------------------------------------------------------------------
// Testbench for custom_subtractor45_3_seq.
// Operations are issued by a driver that pushes the expected result (plain
// integer subtraction) into a scoreboard queue; an independent monitor pops
// and compares whenever the DUT hands off a result.
// ---------------------------------------------------------------------------
module tb_custom_subtractor45_3_seq;

    localparam int AW = 45;
    localparam int BW = 42;
    localparam int DG = 9;
    localparam int ND = AW / DG;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [AW-1:0] a_in = '0;
    logic [BW-1:0] b_in = '0;
    logic          in_ready;
    logic          out_valid;
    logic [AW:0]   diff;
    logic          borrow;

    custom_subtractor45_3_seq #(
        .A_WIDTH(AW),
        .B_WIDTH(BW),
        .DIGIT  (DG)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (a_in),
        .B        (b_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Diff     (diff),
        .Borrow   (borrow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW:0] diff;
        logic        borrow;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   rand_phase = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    logic prev_valid = 1'b0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_out: out_valid=1 with nothing pending, expected 0 (t=%0t)", $time);
                end else begin
                    chk("latency", 64'(cyc - sb[0].acc), 64'(ND));
                end
            end
            if (out_valid && !out_ready && sb.size() != 0) begin
                chk("stall_diff", 64'(diff), 64'(sb[0].diff));
                chk("stall_borrow", 64'(borrow), 64'(sb[0].borrow));
            end
            if (out_valid && out_ready && sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("diff", 64'(diff), 64'(mon_e.diff));
                chk("borrow", 64'(borrow), 64'(mon_e.borrow));
            end
            prev_valid = out_valid;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic issue(input logic [AW-1:0] a, input logic [BW-1:0] b);
        exp_t        e;
        int          n;
        logic [AW:0] ea;
        logic [AW:0] eb;
        @(posedge clk); #1;
        a_in     = a;
        b_in     = b;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: in_ready=0 after %0d cycles, expected 1", n);
            @(posedge clk); #1;
            in_valid = 1'b0;
            return;
        end
        ea = {1'b0, a};
        eb = (AW + 1)'(b);
        e.diff   = ea - eb;
        e.borrow = (ea < eb);
        e.acc    = cyc + 1;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a_in     = AW'({$urandom(), $urandom()});
        b_in     = BW'({$urandom(), $urandom()});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_out_valid(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(out_valid), 64'd1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("rst_in_ready_low", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_diff", 64'(diff), 64'd0);
        chk("rst_borrow", 64'(borrow), 64'd0);
        chk("rst_in_ready_hold", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    endtask

    function automatic logic [AW-1:0] rand_a();
        if ($urandom_range(0, 3) == 0) rand_a = AW'($urandom_range(0, 1000));
        else rand_a = AW'({$urandom(), $urandom()});
    endfunction

    function automatic logic [BW-1:0] rand_b();
        if ($urandom_range(0, 3) == 0) rand_b = BW'($urandom_range(0, 1000));
        else rand_b = BW'({$urandom(), $urandom()});
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [AW-1:0] a_big;
        logic [BW-1:0] b_big;

        // Power-on reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("init_out_valid", 64'(out_valid), 64'd0);
        chk("init_diff", 64'(diff), 64'd0);
        chk("init_borrow", 64'(borrow), 64'd0);
        chk("init_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("init_in_ready_after", 64'(in_ready), 64'd1);

        // Basic case, ready returns the cycle after the handoff
        issue(45'd100, 42'd58);
        wait_out_valid("basic_out_valid");
        @(negedge clk);
        chk("basic_out_valid_drop", 64'(out_valid), 64'd0);
        chk("basic_in_ready_back", 64'(in_ready), 64'd1);

        // Directed boundary values
        issue(45'd0, 42'd1);
        issue(45'd1 << 36, 42'd1);
        a_big = '1;
        b_big = '1;
        issue(a_big, b_big);
        issue(45'd12345, 42'd12345);
        issue(45'd0, b_big);
        issue(a_big, 42'd0);
        drain();

        // Long consumer stall with input noise
        @(posedge clk); #1;
        out_ready = 1'b0;
        issue(45'h1234_5678_9AB, 42'h0FE_DCBA_9876);
        wait_out_valid("stall_out_valid_seen");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            a_in     = AW'({$urandom(), $urandom()});
            b_in     = BW'({$urandom(), $urandom()});
            in_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release_out_valid", 64'(out_valid), 64'd0);
        chk("release_in_ready", 64'(in_ready), 64'd1);
        chk("release_sb_empty", 64'(sb.size()), 64'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("no_extra_out", 64'(out_valid), 64'd0);
        end

        // Reset in the middle of BUSY discards the operation
        issue(45'd100, 42'd58);
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("no_out_after_rst", 64'(out_valid), 64'd0);
        end
        issue(45'd7, 42'd9);
        drain();

        // Randomized traffic with random backpressure
        rand_phase = 1'b1;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    issue(rand_a(), rand_b());
                end
                rand_phase = 1'b0;
            end
            begin
                while (rand_phase) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
